// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types and default timing constants for the RTC scheduler
// Contents:
//   rtc_state_t          scheduler FSM state encoding
//   RTC_POLL_PERIOD_DEF  default clk2 cycles between automatic reads
//   RTC_READ_WAIT_DEF    default clk2 cycles reserved for one read transaction
//   RTC_WRITE_WAIT_DEF   default clk2 cycles reserved for one write transaction
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_STROBE = 3'd1,
        ST_RD_WAIT   = 3'd2,
        ST_RD_LATCH  = 3'd3,
        ST_WR_STROBE = 3'd4,
        ST_WR_WAIT   = 3'd5
    } rtc_state_t;

    localparam int RTC_POLL_PERIOD_DEF = 1000;
    localparam int RTC_READ_WAIT_DEF   = 64;
    localparam int RTC_WRITE_WAIT_DEF  = 112;

endpackage

// File: rtl/rtc_bcd_check.sv
// rtl/rtc_bcd_check.sv - combinational range check of a seconds/minutes BCD sample
// Ports:
//   seconds  in  8  BCD seconds sample
//   minutes  in  8  BCD minutes sample
//   ok       out 1  high when both bytes are valid 00..59 BCD values
module rtc_bcd_check (
    input  logic [7:0] seconds,
    input  logic [7:0] minutes,
    output logic       ok
);

    // A high nibble of at most 5 is also at most 9, so one compare covers both limits.
    assign ok = (seconds[7:4] <= 4'd5) && (seconds[3:0] <= 4'd9) &&
                (minutes[7:4] <= 4'd5) && (minutes[3:0] <= 4'd9);

endmodule

// File: rtl/rtc_scheduler.sv
// rtl/rtc_scheduler.sv - periodic read / on-demand write sequencer for an RTC driver
// Optional feature macro: RTC_SCHED_BCD_CHECK_EN (reject out-of-range BCD samples).
// Parameters:
//   POLL_PERIOD  clk2 cycles between automatic reads
//   READ_WAIT    clk2 cycles spent in RD_WAIT
//   WRITE_WAIT   clk2 cycles spent in WR_WAIT
// Ports:
//   clk2         in  1  clock, rising edge
//   rstn         in  1  synchronous active-low reset
//   poll_en      in  1  enables periodic reads
//   set_req      in  1  pulse requesting a default-time write
//   drv_seconds  in  8  seconds bus from driver
//   drv_minutes  in  8  minutes bus from driver
//   read_n       out 1  active-low read strobe
//   write_n      out 1  active-low write strobe
//   time_sec     out 8  last latched seconds (BCD)
//   time_min     out 8  last latched minutes (BCD)
//   time_valid   out 1  pulse when time_sec/time_min update
//   set_ack      out 1  pulse when a write transaction completes
//   busy         out 1  FSM not idle
//   bcd_err      out 1  sticky invalid-sample flag (0 without the macro)
module rtc_scheduler
    import rtc_pkg::*;
#(
    parameter int POLL_PERIOD = RTC_POLL_PERIOD_DEF,
    parameter int READ_WAIT   = RTC_READ_WAIT_DEF,
    parameter int WRITE_WAIT  = RTC_WRITE_WAIT_DEF
) (
    input  logic       clk2,
    input  logic       rstn,
    input  logic       poll_en,
    input  logic       set_req,
    input  logic [7:0] drv_seconds,
    input  logic [7:0] drv_minutes,
    output logic       read_n,
    output logic       write_n,
    output logic [7:0] time_sec,
    output logic [7:0] time_min,
    output logic       time_valid,
    output logic       set_ack,
    output logic       busy,
    output logic       bcd_err
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

    localparam int WAIT_MAX = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    // Loaded on strobe entry; the wait state exits when the counter reaches zero,
    // giving exactly N cycles in the wait state.
    localparam logic [WW-1:0] RD_LOAD = WW'(READ_WAIT - 1);
    localparam logic [WW-1:0] WR_LOAD = WW'(WRITE_WAIT - 1);

    rtc_state_t    state;
    logic [WW-1:0] wait_cnt;
    logic [PW-1:0] poll_cnt;
    logic          poll_due;
    logic          pending;
    logic          set_again;   // request seen while a write is already in flight
    logic          poll_wrap;
    logic          rd_start;
    logic          wr_done;

    assign poll_wrap = poll_en && (poll_cnt == POLL_LAST);
    assign rd_start  = (state == ST_IDLE) && !pending && poll_due;
    assign wr_done   = (state == ST_WR_WAIT) && (wait_cnt == '0);

    // Poll counter and poll_due. Write completion forces a read of the new time.
    always_ff @(posedge clk2) begin
        if (!rstn) begin
            poll_cnt <= '0;
            poll_due <= 1'b0;
        end else if (!poll_en) begin
            poll_cnt <= '0;
            poll_due <= 1'b0;
        end else begin
            poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
            if (poll_wrap || wr_done) begin
                poll_due <= 1'b1;
            end else if (rd_start) begin
                poll_due <= 1'b0;
            end
        end
    end

    // Write request capture. pending stays set for the whole write; requests that
    // land during the write are folded into one follow-up write.
    always_ff @(posedge clk2) begin
        if (!rstn) begin
            pending   <= 1'b0;
            set_again <= 1'b0;
        end else if (wr_done) begin
            pending   <= set_again | set_req;
            set_again <= 1'b0;
        end else if (set_req) begin
            if (state == ST_WR_STROBE || state == ST_WR_WAIT) begin
                set_again <= 1'b1;
            end else begin
                pending <= 1'b1;
            end
        end
    end

`ifdef RTC_SCHED_BCD_CHECK_EN
    logic sample_ok;

    rtc_bcd_check u_bcd_check (
        .seconds (drv_seconds),
        .minutes (drv_minutes),
        .ok      (sample_ok)
    );
`else
    assign bcd_err = 1'b0;
`endif

    always_ff @(posedge clk2) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            read_n     <= 1'b1;
            write_n    <= 1'b1;
            time_sec   <= 8'h00;
            time_min   <= 8'h00;
            time_valid <= 1'b0;
            set_ack    <= 1'b0;
            busy       <= 1'b0;
`ifdef RTC_SCHED_BCD_CHECK_EN
            bcd_err    <= 1'b0;
`endif
        end else begin
            time_valid <= 1'b0;
            set_ack    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state    <= ST_WR_STROBE;
                        write_n  <= 1'b0;
                        wait_cnt <= WR_LOAD;
                        busy     <= 1'b1;
                    end else if (poll_due) begin
                        state    <= ST_RD_STROBE;
                        read_n   <= 1'b0;
                        wait_cnt <= RD_LOAD;
                        busy     <= 1'b1;
                    end
                end
                ST_RD_STROBE: begin
                    read_n <= 1'b1;
                    state  <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_RD_LATCH;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RD_LATCH: begin
`ifdef RTC_SCHED_BCD_CHECK_EN
                    if (sample_ok) begin
                        time_sec   <= drv_seconds;
                        time_min   <= drv_minutes;
                        time_valid <= 1'b1;
                    end else begin
                        bcd_err <= 1'b1;
                    end
`else
                    time_sec   <= drv_seconds;
                    time_min   <= drv_minutes;
                    time_valid <= 1'b1;
`endif
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_WR_STROBE: begin
                    write_n <= 1'b1;
                    state   <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (wait_cnt == '0) begin
                        state   <= ST_IDLE;
                        set_ack <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    read_n  <= 1'b1;
                    write_n <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rtc_scheduler.md
RTC_SCHEDULER -- requirements
Module: rtc_scheduler

Interface
REQ-001 Parameter POLL_PERIOD, default 1000: clk2 cycles between the start of successive automatic reads.
REQ-002 Parameter READ_WAIT, default 64: clk2 cycles reserved for one Driver read transaction (seconds then minutes).
REQ-003 Parameter WRITE_WAIT, default 112: clk2 cycles reserved for one Driver write transaction (seconds, minutes, hours).
REQ-004 clk2  in  1  sole clock; all logic on its rising edge.
REQ-005 rstn  in  1  reset; synchronous, active-low.
REQ-006 poll_en  in  1  high enables periodic reads.
REQ-007 set_req  in  1  single-cycle pulse requesting a default-time write.
REQ-008 drv_seconds  in  8  Seconds bus from Driver.
REQ-009 drv_minutes  in  8  Minutes bus from Driver.
REQ-010 read_n  out  1  active-low read strobe to Driver.
REQ-011 write_n  out  1  active-low write strobe to Driver.
REQ-012 time_sec  out  8  last latched seconds (BCD).
REQ-013 time_min  out  8  last latched minutes (BCD).
REQ-014 time_valid  out  1  one-cycle pulse when time_sec/time_min update.
REQ-015 set_ack  out  1  one-cycle pulse when a write transaction completes.
REQ-016 busy  out  1  high whenever the FSM is not IDLE.
REQ-017 bcd_err  out  1  sticky invalid-BCD flag (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, RD_STROBE, RD_WAIT, RD_LATCH, WR_STROBE, WR_WAIT.
REQ-019 A free-running poll counter SHALL count 0..POLL_PERIOD-1, wrap to 0, and raise poll_due on wrap; poll_due stays set until a read starts.
REQ-020 The counter SHALL hold at 0 and poll_due SHALL be cleared while poll_en is low.
REQ-021 set_req SHALL be captured in a pending flag regardless of FSM state; further set_req while pending SHALL be absorbed (no queue depth beyond one).
REQ-022 In IDLE, pending write SHALL win over poll_due when both are set in the same cycle.
REQ-023 RD_STROBE SHALL last exactly one cycle with read_n=0; WR_STROBE SHALL last exactly one cycle with write_n=0; strobes SHALL be 1 in all other states.
REQ-024 RD_WAIT SHALL last READ_WAIT cycles, WR_WAIT WRITE_WAIT cycles, timed by one shared wait counter loaded on strobe entry.
REQ-025 RD_LATCH (one cycle) SHALL register drv_seconds/drv_minutes into time_sec/time_min and pulse time_valid the following cycle, then return to IDLE.
REQ-026 WR_WAIT expiry SHALL clear the pending flag, pulse set_ack, return to IDLE, and force a read on the next IDLE cycle (poll_due set).
REQ-027 A set_req arriving during a read SHALL not abort it; it is serviced after RD_LATCH.
REQ-028 Latency set_req (in IDLE) -> write_n low SHALL be 2 cycles (capture, decision).

Reset
REQ-029 While rstn=0 at a clock edge: FSM->IDLE, counters->0, pending and poll_due->0, read_n=write_n=1, time_sec=time_min=8'h00, time_valid=set_ack=busy=bcd_err=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it immediately with no time_valid or set_ack pulse.

Configuration
REQ-031 With RTC_SCHED_BCD_CHECK_EN defined, RD_LATCH SHALL reject a sample whose any nibble >9 or whose high nibble >5: outputs unchanged, no time_valid, bcd_err set until reset.
REQ-032 Without RTC_SCHED_BCD_CHECK_EN, samples SHALL be latched unconditionally and bcd_err SHALL be tied 0.

Structure
REQ-033 Package rtc_pkg SHALL hold the FSM state enum and the default constants for POLL_PERIOD, READ_WAIT, WRITE_WAIT.
REQ-034 Sub-module rtc_bcd_check (combinational nibble-range check) SHALL be instantiated only under the macro; poll counter and FSM stay in rtc_scheduler.

Verification
REQ-035 Reset then poll_en=1, POLL_PERIOD=10, READ_WAIT=4, drv_seconds=8'h42, drv_minutes=8'h17 -> read_n low one cycle ~10 cycles after reset, time_sec=8'h42, time_min=8'h17, one time_valid pulse.
REQ-036 set_req and poll wrap in same cycle -> write_n strobes first, set_ack after WRITE_WAIT, read_n strobes next IDLE cycle.
REQ-037 Three set_req pulses during one WR_WAIT -> exactly one additional write transaction, two set_ack pulses total.
REQ-038 rstn=0 during RD_WAIT -> busy=0 next cycle, no time_valid, time_sec/time_min=8'h00.
REQ-039 Macro defined, drv_seconds=8'h7A -> time_sec unchanged, bcd_err=1 sticky; macro undefined -> time_sec=8'h7A, bcd_err=0.
REQ-040 poll_en=0 for 5*POLL_PERIOD -> read_n stays 1 throughout.
